// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the IF and ID stages.
//   RESET_PC        address of the first instruction fetched after reset
//   IF_ID_BUS_W     width of the IF->ID bus {inst, pc}
//   ID_IF_BUS_W     width of the ID->IF bus {br_taken, br_target}
//   field indices   bit positions of the fields inside both buses
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  localparam int unsigned IF_ID_BUS_W = 64;
  localparam int unsigned ID_IF_BUS_W = 33;

  localparam int unsigned IF_ID_INST_MSB = 63;
  localparam int unsigned IF_ID_INST_LSB = 32;
  localparam int unsigned IF_ID_PC_MSB   = 31;
  localparam int unsigned IF_ID_PC_LSB   = 0;

  localparam int unsigned ID_IF_BR_TAKEN      = 32;
  localparam int unsigned ID_IF_BR_TARGET_MSB = 31;
  localparam int unsigned ID_IF_BR_TARGET_LSB = 0;

  function automatic logic [IF_ID_BUS_W-1:0] pack_if_id(input logic [31:0] inst,
                                                       input logic [31:0] pc);
    return {inst, pc};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction SRAM port plus the IF<->ID handshake.
//   inst_sram_en/we/addr/wdata  fetch stage -> SRAM
//   inst_sram_rdata             SRAM -> fetch stage (1-cycle read latency)
//   id_allowin, id_to_if_bus    ID -> fetch stage ({br_taken, br_target})
//   if_to_id_valid/bus          fetch stage -> ID ({inst, pc})
// Modports: master = fetch stage side, slave = SRAM/ID side.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic                   inst_sram_en;
  logic [3:0]             inst_sram_we;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            inst_sram_wdata;
  logic [31:0]            inst_sram_rdata;
  logic                   id_allowin;
  logic [ID_IF_BUS_W-1:0] id_to_if_bus;
  logic                   if_to_id_valid;
  logic [IF_ID_BUS_W-1:0] if_to_id_bus;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output if_to_id_valid, if_to_id_bus,
    input  inst_sram_rdata, id_allowin, id_to_if_bus
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  if_to_id_valid, if_to_id_bus,
    output inst_sram_rdata, id_allowin, id_to_if_bus
  );
endinterface

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: one-entry holding register for the SRAM read word.
//   clk, reset   core clock, async active-high reset
//   capture      IF is stalled; grab sram_rdata if the buffer is empty
//   clear        word left IF (transfer or branch cancel)
//   sram_rdata   raw SRAM output, only meaningful the cycle after a fetch
//   inst         buffered word when held, otherwise sram_rdata
module fetch_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] sram_rdata,
  output logic [31:0] inst
);
  logic        buf_valid;
  logic [31:0] buf_data;

  // Only the first stalled cycle still sees the fetched word on rdata,
  // so later stalled cycles must not overwrite it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (capture && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= sram_rdata;
    end
  end

  always_comb begin
    inst = buf_valid ? buf_data : sram_rdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: pre-IF + IF stage. Generates nextpc, issues reads to the
// synchronous instruction SRAM, holds the fetched word while ID stalls and
// applies branch redirects from ID.
//   clk, reset     core clock, async active-high reset
//   bus            fetch_stage_if.master (SRAM port + IF<->ID handshake)
//   if_stall_cnt   only when FETCH_STALL_CNT_EN is defined: counts cycles
//                  with a valid IF word refused by ID (wrapping)
// Parameter RESET_PC: address of the first fetch after reset.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]   if_stall_cnt
`endif
);
  logic        if_valid;
  logic [31:0] if_pc;
  logic        br_pending;
  logic [31:0] br_pend_target;

  logic        br_taken;
  logic [31:0] br_target;
  logic        if_ready_go;
  logic        if_allowin;
  logic [31:0] nextpc;
  logic        if_to_id_valid_w;
  logic        to_id_fire;
  logic [31:0] inst;

  always_comb begin
    br_taken         = bus.id_to_if_bus[ID_IF_BR_TAKEN];
    br_target        = bus.id_to_if_bus[ID_IF_BR_TARGET_MSB:ID_IF_BR_TARGET_LSB];
    if_ready_go      = 1'b1;
    if_allowin       = !if_valid || (if_ready_go && bus.id_allowin);
    nextpc           = br_taken   ? br_target      :
                       br_pending ? br_pend_target : if_pc + 32'd4;
    if_to_id_valid_w = if_valid && !br_taken;
    to_id_fire       = if_to_id_valid_w && bus.id_allowin;
  end

  always_comb begin
    bus.inst_sram_en    = !reset && if_allowin;
    bus.inst_sram_we    = 4'h0;
    bus.inst_sram_addr  = nextpc;
    bus.inst_sram_wdata = '0;
    bus.if_to_id_valid  = if_to_id_valid_w;
    bus.if_to_id_bus    = if_valid ? pack_if_id(inst, if_pc) : '0;
  end

  // A branch that arrives while IF is stalled kills the IF word and parks
  // the target; the kill makes IF empty, so the target issues next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid       <= 1'b0;
      if_pc          <= RESET_PC - 32'd4;
      br_pending     <= 1'b0;
      br_pend_target <= '0;
    end else begin
      if (if_allowin) begin
        if_valid <= 1'b1;
        if_pc    <= nextpc;
      end else if (br_taken) begin
        if_valid <= 1'b0;
      end

      if (br_taken && !if_allowin) begin
        br_pending     <= 1'b1;
        br_pend_target <= br_target;
      end else if (if_allowin) begin
        br_pending     <= 1'b0;
      end
    end
  end

  fetch_inst_buf u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .capture    (if_valid && !bus.id_allowin),
    .clear      (to_id_fire || br_taken),
    .sram_rdata (bus.inst_sram_rdata),
    .inst       (inst)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (if_to_id_valid_w && !bus.id_allowin) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_comb begin
    if_stall_cnt = stall_cnt;
  end
`endif
endmodule
